x4l_spi_arbiter: RTL and testbench

- Shares one byte-level SPI shift engine between NREQ requesters, e.g. the Z80 I/O port and a boot/DMA loader.
- Uses round-robin arbitration.
- Owns the slave chip-selects.
- Keeps CS asserted across multi-byte transactions when the owner holds LOCK.
- Releases a stalled lock after a timeout.
- Sits between the requesters and the SPI engine; the engine only sees START/TXD and returns DONE/RXD.

---
 rtl/x4l_spi_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_x4l_spi_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x4l_spi_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI engine between NREQ requesters.
// Owns the chip selects and keeps CS low across locked multi-byte transactions.
module x4l_spi_arbiter #(
  parameter int NREQ = 2,
  parameter int NSLV = 2,
  parameter int SELW = (NSLV > 1) ? $clog2(NSLV) : 1,
  parameter int TOUT = 255
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      LOCK,
  input  logic [NREQ*SELW-1:0] SEL,
  input  logic [NREQ*8-1:0]    TXD,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      DONE,
  output logic [7:0]           RXD,
  output logic                 TIMEOUT,
  output logic [NSLV-1:0]      SPI_CS_N,
  output logic                 ENG_START,
  output logic [7:0]           ENG_TXD,
  input  logic                 ENG_BUSY,
  input  logic                 ENG_DONE,
  input  logic [7:0]           ENG_RXD
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [PW-1:0]   owner_reg, owner_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [7:0]      byte_reg, byte_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic [NSLV-1:0] cs_n_reg, cs_n_next;
  logic [7:0]      rxd_reg, rxd_next;
  logic            tout_reg, tout_next;
  logic            start_reg, start_next;
  logic [7:0]      eng_txd_reg, eng_txd_next;

  logic [SELW-1:0] sel_arr [NREQ];
  logic [7:0]      txd_arr [NREQ];
  logic [PW-1:0]   win_idx;
  int              best_dist;
  logic            timer_expired;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign sel_arr[gi] = SEL[gi*SELW +: SELW];
    assign txd_arr[gi] = TXD[gi*8 +: 8];
  end

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (int'(idx) == j) onehot[j] = 1'b1;
    end
  endfunction

  // Out-of-range slave index leaves every chip select high.
  function automatic logic [NSLV-1:0] cs_decode(input logic [SELW-1:0] s);
    cs_decode = '1;
    for (int j = 0; j < NSLV; j++) begin
      if (int'(s) == j) cs_decode[j] = 1'b0;
    end
  endfunction

  // Winner is the requester closest after ptr_reg, wrapping modulo NREQ.
  always_comb begin
    best_dist = NREQ;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (REQ[i] && (((i + NREQ - 1 - int'(ptr_reg)) % NREQ) < best_dist)) begin
        best_dist = (i + NREQ - 1 - int'(ptr_reg)) % NREQ;
        win_idx   = PW'(i);
      end
    end
  end

  assign timer_expired = (timer_reg == TW'(TOUT - 1));

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (|REQ) state_next = S_ISSUE;
      S_ISSUE: if (!ENG_BUSY) state_next = S_WAIT;
      S_WAIT:  if (ENG_DONE) state_next = LOCK[owner_reg] ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (REQ[owner_reg])       state_next = S_ISSUE;
        else if (!LOCK[owner_reg]) state_next = S_IDLE;
        else if (timer_expired)    state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    byte_next    = byte_reg;
    timer_next   = timer_reg;
    gnt_next     = gnt_reg;
    cs_n_next    = cs_n_reg;
    rxd_next     = rxd_reg;
    eng_txd_next = eng_txd_reg;
    done_next    = '0;
    tout_next    = 1'b0;
    start_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|REQ) begin
          owner_next = win_idx;
          gnt_next   = onehot(win_idx);
          byte_next  = txd_arr[win_idx];
          cs_n_next  = cs_decode(sel_arr[win_idx]);
        end
      end
      S_ISSUE: begin
        if (!ENG_BUSY) begin
          start_next   = 1'b1;
          eng_txd_next = byte_reg;
        end
      end
      S_WAIT: begin
        if (ENG_DONE) begin
          rxd_next  = ENG_RXD;
          done_next = onehot(owner_reg);
          if (LOCK[owner_reg]) begin
            timer_next = '0;
          end else begin
            gnt_next  = '0;
            cs_n_next = '1;
            ptr_next  = owner_reg;
          end
        end
      end
      S_HOLD: begin
        if (REQ[owner_reg]) begin
          byte_next  = txd_arr[owner_reg];
          timer_next = '0;
        end else if (!LOCK[owner_reg] || timer_expired) begin
          gnt_next  = '0;
          cs_n_next = '1;
          ptr_next  = owner_reg;
          tout_next = LOCK[owner_reg];
        end else if (timer_reg != {TW{1'b1}}) begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      owner_reg   <= '0;
      ptr_reg     <= PW'(NREQ - 1);
      byte_reg    <= '0;
      timer_reg   <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      cs_n_reg    <= '1;
      rxd_reg     <= '0;
      tout_reg    <= 1'b0;
      start_reg   <= 1'b0;
      eng_txd_reg <= '0;
    end else begin
      owner_reg   <= owner_next;
      ptr_reg     <= ptr_next;
      byte_reg    <= byte_next;
      timer_reg   <= timer_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      cs_n_reg    <= cs_n_next;
      rxd_reg     <= rxd_next;
      tout_reg    <= tout_next;
      start_reg   <= start_next;
      eng_txd_reg <= eng_txd_next;
    end
  end

  assign GNT       = gnt_reg;
  assign DONE      = done_reg;
  assign RXD       = rxd_reg;
  assign TIMEOUT   = tout_reg;
  assign SPI_CS_N  = cs_n_reg;
  assign ENG_START = start_reg;
  assign ENG_TXD   = eng_txd_reg;

endmodule

// File: tb/tb_x4l_spi_arbiter.sv
// Bench for x4l_spi_arbiter: directed stimulus, an SPI engine stand-in that returns
// TXD^8'h99, and a transaction-level reference model compared every cycle.
module tb_x4l_spi_arbiter;
  localparam int NREQ = 2;
  localparam int NSLV = 2;
  localparam int SELW = 1;
  localparam int TOUT = 8;

  logic              CLK;
  logic              nRESET;
  logic [NREQ-1:0]   REQ;
  logic [NREQ-1:0]   LOCK;
  logic [NREQ*SELW-1:0] SEL;
  logic [NREQ*8-1:0] TXD;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   DONE;
  logic [7:0]        RXD;
  logic              TIMEOUT;
  logic [NSLV-1:0]   SPI_CS_N;
  logic              ENG_START;
  logic [7:0]        ENG_TXD;
  logic              ENG_BUSY;
  logic              ENG_DONE;
  logic [7:0]        ENG_RXD;

  x4l_spi_arbiter #(.NREQ(NREQ), .NSLV(NSLV), .SELW(SELW), .TOUT(TOUT)) dut (
    .CLK(CLK), .nRESET(nRESET), .REQ(REQ), .LOCK(LOCK), .SEL(SEL), .TXD(TXD),
    .GNT(GNT), .DONE(DONE), .RXD(RXD), .TIMEOUT(TIMEOUT), .SPI_CS_N(SPI_CS_N),
    .ENG_START(ENG_START), .ENG_TXD(ENG_TXD), .ENG_BUSY(ENG_BUSY),
    .ENG_DONE(ENG_DONE), .ENG_RXD(ENG_RXD)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine stand-in: busy 3 cycles after START, then DONE with TXD^8'h99.
  int         eng_cnt = 0;
  logic [7:0] eng_cap = 8'h00;
  logic       force_busy = 1'b0;
  always @(negedge CLK) begin
    ENG_DONE = 1'b0;
    if (!nRESET) begin
      eng_cnt = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        ENG_DONE = 1'b1;
        ENG_RXD  = eng_cap ^ 8'h99;
      end
    end else if (ENG_START) begin
      eng_cnt = 3;
      eng_cap = ENG_TXD;
    end
    ENG_BUSY = (eng_cnt != 0) || force_busy;
  end

  // Reference model: owner index (-1 = none), phase 0 idle / 1 issue / 2 wait / 3 hold.
  int         m_owner = -1, m_ph = 0, m_ptr = NREQ - 1, m_sel = 0, m_timer = 0;
  logic [7:0] m_byte = 8'h00;
  logic [NREQ-1:0] exp_done = '0;
  logic       exp_tout = 1'b0, exp_start = 1'b0;
  logic [7:0] exp_rxd = 8'h00, exp_txd = 8'h00;

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      m_owner = -1; m_ph = 0; m_ptr = NREQ - 1; m_sel = 0; m_timer = 0; m_byte = 8'h00;
      exp_done = '0; exp_tout = 1'b0; exp_start = 1'b0; exp_rxd = 8'h00; exp_txd = 8'h00;
    end else begin
      exp_done = '0; exp_tout = 1'b0; exp_start = 1'b0;
      case (m_ph)
        0: if (REQ != 0) begin
          for (int k = 1; k <= NREQ; k++)
            if (m_owner < 0 && REQ[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
          m_sel  = int'(SEL[m_owner*SELW +: SELW]);
          m_byte = TXD[m_owner*8 +: 8];
          m_ph   = 1;
        end
        1: if (!ENG_BUSY) begin
          exp_start = 1'b1; exp_txd = m_byte; m_ph = 2;
        end
        2: if (ENG_DONE) begin
          exp_rxd = ENG_RXD; exp_done[m_owner] = 1'b1;
          if (LOCK[m_owner]) begin m_ph = 3; m_timer = 0; end
          else begin m_ptr = m_owner; m_owner = -1; m_ph = 0; end
        end
        default: begin
          if (REQ[m_owner]) begin
            m_byte = TXD[m_owner*8 +: 8]; m_timer = 0; m_ph = 1;
          end else if (!LOCK[m_owner]) begin
            m_ptr = m_owner; m_owner = -1; m_ph = 0;
          end else if (m_timer == TOUT - 1) begin
            exp_tout = 1'b1; m_ptr = m_owner; m_owner = -1; m_ph = 0;
          end else begin
            m_timer++;
          end
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    logic [NREQ-1:0] eg;
    logic [NSLV-1:0] ec;
    eg = '0;
    ec = '1;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (m_sel < NSLV) ec[m_sel] = 1'b0;
    end
    if (cmp_on) begin
      chk("cyc_gnt", GNT, eg);
      chk("cyc_cs_n", SPI_CS_N, ec);
      chk("cyc_done", DONE, exp_done);
      chk("cyc_timeout", TIMEOUT, exp_tout);
      chk("cyc_eng_start", ENG_START, exp_start);
      chk("cyc_eng_txd", ENG_TXD, exp_txd);
      chk("cyc_rxd", RXD, exp_rxd);
    end
  end

  task automatic wait_done(input int r, input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (DONE[r]) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 nRESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
  endtask

  initial begin
    int seq[$];
    int gap;
    int k;
    bit ok;
    logic [NREQ-1:0] prev_g;
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;

    nRESET = 1'b0; REQ = '0; LOCK = '0; SEL = '0; TXD = '0;
    ENG_BUSY = 1'b0; ENG_DONE = 1'b0; ENG_RXD = 8'h00;
    repeat (3) @(negedge CLK);
    cmp_on = 1;
    chk("rst_gnt", GNT, 0);
    chk("rst_cs_n", SPI_CS_N, 2'b11);
    chk("rst_txd", ENG_TXD, 0);
    chk("rst_rxd", RXD, 0);
    nRESET = 1'b1;
    @(negedge CLK);

    // Single byte from requester 0 to slave 1.
    SEL[0] = 1'b1; TXD[7:0] = 8'hA5; REQ[0] = 1'b1;
    @(negedge CLK);
    chk("t1_gnt", GNT, 2'b01);
    chk("t1_cs_n", SPI_CS_N, 2'b01);
    @(negedge CLK);
    chk("t1_start", ENG_START, 1);
    chk("t1_eng_txd", ENG_TXD, 8'hA5);
    wait_done(0, "t1_done");
    REQ[0] = 1'b0;
    chk("t1_rxd", RXD, 8'h3C);
    chk("t1_cs_rel", SPI_CS_N, 2'b11);
    chk("t1_gnt_rel", GNT, 0);

    // Both requesting continuously: grants alternate 0,1,0,1 with a CS-high gap.
    do_reset();
    SEL = 2'b10; TXD = {8'h66, 8'h55}; LOCK = '0; REQ = 2'b11;
    gap = 0; prev_g = '0;
    for (int c = 0; c < 200 && seq.size() < 4; c++) begin
      @(negedge CLK);
      if (GNT == '0) begin
        gap++;
      end else if (prev_g == '0) begin
        seq.push_back(GNT == 2'b01 ? 0 : 1);
        if (seq.size() > 1) chk("t2_gap", gap, 1);
        gap = 0;
      end
      prev_g = GNT;
    end
    chk("t2_count", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) chk("t2_order", seq[i], i % 2);
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (GNT == '0) break;
    end
    REQ = '0;

    // Locked 4-byte burst from requester 1 while requester 0 waits.
    @(negedge CLK);
    SEL = 2'b01; TXD[15:8] = bytes[0]; LOCK[1] = 1'b1; REQ[1] = 1'b1;
    @(negedge CLK);
    TXD[7:0] = 8'h5A; REQ[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wait_done(1, "t3_done");
      chk("t3_gnt", GNT, 2'b10);
      chk("t3_cs_n", SPI_CS_N, 2'b10);
      chk("t3_rxd", RXD, bytes[b] ^ 8'h99);
      if (b < 3) TXD[15:8] = bytes[b+1];
      else       REQ[1] = 1'b0;
    end
    repeat (2) begin
      @(negedge CLK);
      chk("t3_hold_gnt", GNT, 2'b10);
    end
    LOCK[1] = 1'b0;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (GNT == 2'b01) begin ok = 1; break; end
    end
    chk("t3_gnt0", ok, 1);
    chk("t3_cs0", SPI_CS_N, 2'b01);
    wait_done(0, "t3_done0");
    REQ[0] = 1'b0;
    chk("t3_rxd0", RXD, 8'hC3);

    // Stalled lock released by the hold timer.
    @(negedge CLK);
    SEL = 2'b00; TXD[7:0] = 8'h3C; LOCK[0] = 1'b1; REQ[0] = 1'b1;
    wait_done(0, "t4_done");
    REQ[0] = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      k++;
      if (TIMEOUT) break;
    end
    chk("t4_tout_cycles", k, 8);
    chk("t4_gnt", GNT, 0);
    chk("t4_cs_n", SPI_CS_N, 2'b11);
    LOCK[0] = 1'b0;
    @(negedge CLK);
    chk("t4_tout_pulse", TIMEOUT, 0);

    // Engine busy for 5 cycles on entering ISSUE.
    force_busy = 1'b1;
    @(negedge CLK);
    SEL = 2'b01; TXD[7:0] = 8'h77; REQ[0] = 1'b1;
    @(posedge CLK); #1;
    chk("t5_gnt", GNT, 2'b01);
    repeat (5) begin
      @(posedge CLK); #1;
      chk("t5_no_start", ENG_START, 0);
    end
    force_busy = 1'b0;
    @(posedge CLK); #1;
    chk("t5_start", ENG_START, 1);
    chk("t5_eng_txd", ENG_TXD, 8'h77);
    @(posedge CLK); #1;
    chk("t5_start_once", ENG_START, 0);
    wait_done(0, "t5_done");
    REQ[0] = 1'b0;
    chk("t5_rxd", RXD, 8'hEE);

    // Reset asserted while waiting on the engine.
    @(negedge CLK);
    SEL = 2'b01; TXD[7:0] = 8'h42; REQ[0] = 1'b1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (ENG_START) begin ok = 1; break; end
    end
    chk("t6_start", ok, 1);
    @(negedge CLK);
    #2 nRESET = 1'b0;
    #1;
    chk("t6_async_cs", SPI_CS_N, 2'b11);
    chk("t6_async_gnt", GNT, 0);
    REQ[0] = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    SEL = 2'b00; TXD[7:0] = 8'h5A; REQ[0] = 1'b1;
    @(negedge CLK);
    chk("t6_gnt", GNT, 2'b01);
    chk("t6_cs_n", SPI_CS_N, 2'b10);
    wait_done(0, "t6_done");
    REQ[0] = 1'b0;
    chk("t6_rxd", RXD, 8'hC3);
    repeat (4) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
